// File: rtl/div_restoring_nbit_if.sv
// Handshake and operand/result bundle for the restoring divider.
// master = requester (drives start and operands), slave = the divider.
interface div_restoring_nbit_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_restoring_nbit.sv
// Sequential N-bit restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds one sign-fix cycle).
module div_restoring_nbit #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    div_restoring_nbit_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  r_q, r_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
`endif

    // Partial remainder never exceeds the divisor, so N bits hold it; the trial subtract uses N+1.
    logic [N:0]    r_shift, trial;
    logic [N-1:0]  q_next, r_next;
    logic [N-1:0]  a_mag, b_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
        a_mag   = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
        b_mag   = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
`else
        a_mag   = bus.dividend;
        b_mag   = bus.divisor;
`endif
        r_shift = {r_q, q_q[N-1]};
        trial   = r_shift - {1'b0, d_q};
        r_next  = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
        q_next  = {q_q[N-2:0], ~trial[N]};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    r_d    = '0;
                    d_d    = b_mag;
                    zero_d = (bus.divisor == '0);
                    // Keep the raw dividend for a zero divisor: it becomes the remainder.
                    q_d    = (bus.divisor == '0) ? bus.dividend : a_mag;
                    dbz_d  = 1'b0;
`ifdef DIV_SIGNED_EN
                    negq_d = bus.dividend[N-1] ^ bus.divisor[N-1];
                    negr_d = bus.dividend[N-1];
`endif
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A zero divisor spends one RUN cycle without iterating, then reports.
                if (zero_q) begin
                    quot_d  = '1;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    q_d   = q_next;
                    r_d   = r_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
`ifdef DIV_SIGNED_EN
                        state_d = SIGN;
`else
                        quot_d  = q_next;
                        rem_d   = r_next;
                        state_d = DONE;
`endif
                    end
                end
            end
            SIGN: begin
`ifdef DIV_SIGNED_EN
                quot_d = negq_q ? -q_q : q_q;
                rem_d  = negr_q ? -r_q : r_q;
`endif
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign bus.ready       = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy        = (state_q == RUN) || (state_q == SIGN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
